uart_frame_parser: RTL and testbench

- Sits directly downstream of the UART byte receiver and consumes its per-byte done pulse and data.
- Assembles bytes into framed command packets: header 0x55 0xAA, CMD, LEN, LEN payload bytes, then checksum.
- Streams payload bytes to the user logic as they arrive.
- Reports frame completion or one of three error types.

---
 rtl/uart_frame_parser.sv | 142 ++++++++++++++
 tb/tb_uart_frame_parser.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Frame parser behind a UART byte receiver: 55 AA CMD LEN payload CHK.
// Payload bytes stream out as they arrive; the frame ends in one done or error pulse.
module uart_frame_parser #(
    parameter int CLK_FRE       = 25_000_000,
    parameter int BPS           = 9_600,
    parameter int MAX_LEN       = 16,
    parameter int TIMEOUT_BYTES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       uart_rx_done,
    input  logic [7:0] uart_rx_data,
    output logic [7:0] pkt_cmd,
    output logic [7:0] pkt_len,
    output logic       pkt_data_vld,
    output logic [7:0] pkt_data,
    output logic [7:0] pkt_data_idx,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic [1:0] err_code
);

    localparam int TO_CNT = (CLK_FRE / BPS) * 10 * TIMEOUT_BYTES;
    localparam int TO_W   = $clog2(TO_CNT + 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_CNT - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_CHK = 2'd1;
    localparam logic [1:0] ERR_LEN = 2'd2;
    localparam logic [1:0] ERR_TO  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR2,
        S_CMD,
        S_LEN,
        S_DATA,
        S_CHK
    } state_t;

    state_t          state_q;
    logic [7:0]      cmd_q, len_q, data_q, idx_q, cnt_q, csum_q;
    logic [TO_W-1:0] to_q;
    logic            vld_q, done_q, err_q;
    logic [1:0]      code_q;
    logic            in_frame;

    // The silence timer only matters once the header has been accepted.
    assign in_frame = (state_q == S_CMD) || (state_q == S_LEN) ||
                      (state_q == S_DATA) || (state_q == S_CHK);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            to_q    <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (uart_rx_done) begin
                // A byte always wins over a coincident timeout expiry.
                to_q <= '0;
                case (state_q)
                    S_IDLE: begin
                        if (uart_rx_data == 8'h55) state_q <= S_HDR2;
                    end
                    S_HDR2: begin
                        if (uart_rx_data == 8'hAA)      state_q <= S_CMD;
                        else if (uart_rx_data == 8'h55) state_q <= S_HDR2;
                        else                            state_q <= S_IDLE;
                    end
                    S_CMD: begin
                        cmd_q   <= uart_rx_data;
                        csum_q  <= uart_rx_data;
                        state_q <= S_LEN;
                    end
                    S_LEN: begin
                        len_q  <= uart_rx_data;
                        csum_q <= csum_q + uart_rx_data;
                        if (uart_rx_data > MAX_LEN_B) begin
                            err_q   <= 1'b1;
                            code_q  <= ERR_LEN;
                            state_q <= S_IDLE;
                        end else if (uart_rx_data == 8'd0) begin
                            state_q <= S_CHK;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        vld_q  <= 1'b1;
                        data_q <= uart_rx_data;
                        idx_q  <= cnt_q;
                        csum_q <= csum_q + uart_rx_data;
                        cnt_q  <= cnt_q + 8'd1;
                        if (cnt_q == len_q - 8'd1) state_q <= S_CHK;
                    end
                    S_CHK: begin
                        if (uart_rx_data == csum_q) begin
                            done_q <= 1'b1;
                        end else begin
                            err_q  <= 1'b1;
                            code_q <= ERR_CHK;
                        end
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (in_frame) begin
                if (to_q == TO_LAST) begin
                    err_q   <= 1'b1;
                    code_q  <= ERR_TO;
                    to_q    <= '0;
                    state_q <= S_IDLE;
                end else begin
                    to_q <= to_q + 1'b1;
                end
            end
        end
    end

    assign pkt_cmd      = cmd_q;
    assign pkt_len      = len_q;
    assign pkt_data_vld = vld_q;
    assign pkt_data     = data_q;
    assign pkt_data_idx = idx_q;
    assign pkt_done     = done_q;
    assign pkt_err      = err_q;
    assign err_code     = code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a 200-cycle timeout (1 kHz clock, 100 baud).
module tb_uart_frame_parser;

  logic       clk;
  logic       rstn;
  logic       uart_rx_done;
  logic [7:0] uart_rx_data;
  logic [7:0] pkt_cmd, pkt_len, pkt_data, pkt_data_idx;
  logic       pkt_data_vld, pkt_done, pkt_err;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  // Output snapshot taken on the falling edge after each byte is accepted.
  logic       s_vld, s_done, s_err;
  logic [7:0] s_data, s_idx;
  logic [1:0] s_code;

  uart_frame_parser #(
    .CLK_FRE(1000),
    .BPS(100),
    .MAX_LEN(16),
    .TIMEOUT_BYTES(2)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .uart_rx_done(uart_rx_done),
    .uart_rx_data(uart_rx_data),
    .pkt_cmd(pkt_cmd),
    .pkt_len(pkt_len),
    .pkt_data_vld(pkt_data_vld),
    .pkt_data(pkt_data),
    .pkt_data_idx(pkt_data_idx),
    .pkt_done(pkt_done),
    .pkt_err(pkt_err),
    .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; presents one byte for one cycle.
  task automatic send_byte(input logic [7:0] b);
    uart_rx_data = b;
    uart_rx_done = 1'b1;
    @(negedge clk);
    uart_rx_done = 1'b0;
    s_vld  = pkt_data_vld;
    s_data = pkt_data;
    s_idx  = pkt_data_idx;
    s_done = pkt_done;
    s_err  = pkt_err;
    s_code = err_code;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd"}, 32'(pkt_cmd), 0);
    chk({tag, "_len"}, 32'(pkt_len), 0);
    chk({tag, "_vld"}, 32'(pkt_data_vld), 0);
    chk({tag, "_data"}, 32'(pkt_data), 0);
    chk({tag, "_idx"}, 32'(pkt_data_idx), 0);
    chk({tag, "_done"}, 32'(pkt_done), 0);
    chk({tag, "_err"}, 32'(pkt_err), 0);
    chk({tag, "_code"}, 32'(err_code), 0);
  endtask

  // Sends 55 AA 01 03 11 22 33 <ck> and checks the three payload pulses.
  task automatic nominal_frame(input string tag, input logic [7:0] ck);
    logic [7:0] pl [3];
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_byte(8'h55); chk({tag, "_h1_err"}, 32'(s_err), 0);
    send_byte(8'hAA); chk({tag, "_h2_err"}, 32'(s_err), 0);
    send_byte(8'h01); chk({tag, "_cmd_vld"}, 32'(s_vld), 0);
    send_byte(8'h03); chk({tag, "_len_vld"}, 32'(s_vld), 0);
    for (int i = 0; i < 3; i++) begin
      send_byte(pl[i]);
      chk({tag, "_pl_vld"}, 32'(s_vld), 1);
      chk({tag, "_pl_data"}, 32'(s_data), 32'(pl[i]));
      chk({tag, "_pl_idx"}, 32'(s_idx), 32'(i));
      chk({tag, "_pl_err"}, 32'(s_err), 0);
    end
    send_byte(ck);
  endtask

  initial begin
    int n;
    int vld_cnt;
    rstn = 1'b0;
    uart_rx_done = 1'b0;
    uart_rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Nominal frame, checksum 01+03+11+22+33 = 6A.
    nominal_frame("nom", 8'h6A);
    chk("nom_done", 32'(s_done), 1);
    chk("nom_err", 32'(s_err), 0);
    chk("nom_cmd", 32'(pkt_cmd), 32'h01);
    chk("nom_len", 32'(pkt_len), 32'h03);
    @(negedge clk);
    chk("nom_done_pulse", 32'(pkt_done), 0);

    // Same frame with a wrong checksum.
    nominal_frame("bad", 8'h6B);
    chk("bad_done", 32'(s_done), 0);
    chk("bad_err", 32'(s_err), 1);
    chk("bad_code", 32'(s_code), 1);

    // Zero-length frame goes straight to the checksum.
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h07);
    send_byte(8'h00); chk("zl_len_vld", 32'(s_vld), 0);
    send_byte(8'h07);
    chk("zl_vld", 32'(s_vld), 0);
    chk("zl_done", 32'(s_done), 1);
    chk("zl_len", 32'(pkt_len), 0);

    // LEN=17 exceeds the limit, then a valid frame 03 01 44 48.
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01);
    send_byte(8'h11);
    chk("ovl_err", 32'(s_err), 1);
    chk("ovl_code", 32'(s_code), 2);
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03); send_byte(8'h01);
    send_byte(8'h44);
    chk("post_vld", 32'(s_vld), 1);
    chk("post_idx", 32'(s_idx), 0);
    send_byte(8'h48);
    chk("post_done", 32'(s_done), 1);
    chk("post_code_hold", 32'(err_code), 2);
    chk("post_cmd", 32'(pkt_cmd), 32'h03);

    // Timeout: count clock edges from the last byte's edge to the error.
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01);
    n = 0;
    while (!pkt_err && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", 32'(n), 200);
    chk("to_code", 32'(err_code), 3);
    @(negedge clk);
    chk("to_pulse", 32'(pkt_err), 0);

    // A byte on the expiry edge suppresses the timeout.
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01);
    repeat (199) @(negedge clk);
    chk("exp_pre_err", 32'(pkt_err), 0);
    send_byte(8'h03);
    chk("exp_err", 32'(s_err), 0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    chk("exp_idx", 32'(s_idx), 2);
    send_byte(8'h6A);
    chk("exp_done", 32'(s_done), 1);

    // Resync through garbage and a repeated 55; checksum 02+01+5A = 5D.
    vld_cnt = 0;
    send_byte(8'h13); vld_cnt += int'(s_vld);
    send_byte(8'h55); vld_cnt += int'(s_vld);
    send_byte(8'h55); vld_cnt += int'(s_vld);
    send_byte(8'hAA); vld_cnt += int'(s_vld);
    send_byte(8'h02); vld_cnt += int'(s_vld);
    send_byte(8'h01); vld_cnt += int'(s_vld);
    send_byte(8'h5A); vld_cnt += int'(s_vld);
    chk("rs_data", 32'(s_data), 32'h5A);
    chk("rs_idx", 32'(s_idx), 0);
    send_byte(8'h5D); vld_cnt += int'(s_vld);
    chk("rs_done", 32'(s_done), 1);
    chk("rs_cmd", 32'(pkt_cmd), 32'h02);
    chk("rs_vld_cnt", 32'(vld_cnt), 1);

    // Reset in the middle of the payload.
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h03);
    send_byte(8'h11);
    rstn = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    chk("mid_rst_done", 32'(pkt_done), 0);
    chk("mid_rst_err", 32'(pkt_err), 0);
    rstn = 1'b1;
    @(negedge clk);
    nominal_frame("after_rst", 8'h6A);
    chk("after_rst_done", 32'(s_done), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
